sweep_capture_engine: RTL and testbench
=======================================

# sweep_capture_engine

Parametrised on-chip exhaustive stimulus/response engine for the trojan-detection benchmark flow. On `start` it drives every input vector 0 … 2^N_IN−1 into a small combinational DUT, holds each vector for a settle interval, and captures the DUT response. It stores each response, compresses the stream into a MISR signature, and compares each response against an externally supplied expected value. This replaces file-based fixed 2-input sweeps with a synthesizable sweep of any width, usable in both simulation and silicon.

## Interface
- N_IN, 2: DUT input width; number of vectors is 2^N_IN (1..12).
- N_OUT, 1: DUT output width (1..SIG_W).
- SETTLE, 1: extra hold cycles before each capture (0..255).
- SIG_W, 16: MISR width.
- POLY, 16'h1021: MISR feedback polynomial.
- SEED, all-ones: MISR value loaded at `start`.
- CK  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- dut_in  out  N_IN  vector driven to DUT, registered.
- dut_out  in  N_OUT  DUT response.
- exp_out  in  N_OUT  expected response for current `dut_in`, from external golden ROM, combinational.
- rd_addr  in  N_IN  response buffer read address.
- rd_data  out  N_OUT  buffer contents at `rd_addr`, registered.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next accepted `start` or reset.
- signature  out  SIG_W  MISR value.
- mismatch  out  1  at least one capture differed from `exp_out`.
- fail_count  out  N_IN+1  number of differing captures.
- first_fail_addr  out  N_IN  vector index of first differing capture.

## Operation
- States: IDLE, HOLD, CAPTURE, DONE.
- IDLE/DONE with `start`:
  - vec←0, signature←SEED, mismatch←0, fail_count←0, first_fail_addr←0, done←0.
  - Next state is HOLD, or CAPTURE directly if SETTLE=0.
- HOLD: `dut_in`=vec; counts SETTLE cycles, then moves to CAPTURE.
- CAPTURE actions:
  - Writes mem[vec]←dut_out.
  - Updates signature: sig←{sig[SIG_W−2:0],0} ^ (sig[SIG_W−1] ? POLY : 0) ^ zero-extended dut_out.
  - If dut_out≠exp_out: fail_count+1; mismatch←1; first_fail_addr←vec if this is the first failure.
- CAPTURE exit: if vec = 2^N_IN−1, go to DONE; else vec+1 (no wrap beyond max) and go to HOLD/CAPTURE.
- `start` while busy is ignored. `start` in DONE restarts and clears all results; the buffer is overwritten progressively.
- busy=1 in HOLD and CAPTURE; done=1 only in DONE.
- Read port: rd_data = mem[rd_addr] one cycle later, in any state. A read of the address written in the same cycle returns the old data.
- fail_count never overflows; its maximum is 2^N_IN.

## Timing
- `start` is sampled in cycle t; `dut_in`=0 from cycle t+1.
- Each vector is held for SETTLE+1 cycles; capture occurs in the last of them.
- Last capture at t+2^N_IN·(SETTLE+1); done=1 from t+2^N_IN·(SETTLE+1)+1.
- signature, mismatch and fail_count update in the cycle after each capture.
- Reset values: dut_in=0, rd_data=0, busy=0, done=0, signature=0, mismatch=0, fail_count=0, first_fail_addr=0, state IDLE.
- Reset mid-sweep aborts in the same edge; buffer contents are undefined afterwards.
- reset has priority over start.

## Structure
- Shared package `sweep_pkg`:
  - state enum type `sweep_state_t`.
  - MISR step function `misr_step(sig, din, poly)`, reused by benches as the reference model.
- Sub-module `sweep_resp_ram`: simple dual-port RAM, depth 2^N_IN, width N_OUT, registered read.
- FSM, counters, MISR and compare logic stay in the top module.

## Test plan
Defaults unless stated: N_IN=2, N_OUT=1, SETTLE=1, SEED=FFFF, POLY=1021.
- AND-gate DUT, exp_out = AND, `start` pulse → dut_in 0,1,2,3 each held 2 cycles. done rises exactly 9 cycles after start. signature=16'h0E1E, mismatch=0, fail_count=0. rd_addr 0..3 → 0,0,0,1.
- Same DUT, exp_out = OR → mismatch=1, fail_count=2, first_fail_addr=1.
- SETTLE=0 → one vector per cycle; done 5 cycles after start; same signature 16'h0E1E.
- reset asserted in the cycle after the 2nd capture → all outputs 0 next cycle, state IDLE. A new start produces a full correct sweep.
- `start` pulsed while busy → ignored, timing unchanged. `start` in DONE → done falls next cycle, results cleared, sweep repeats with an identical signature.
- N_IN=4, N_OUT=2, DUT = 2-bit sum of input halves → 16 captures. Buffer matches the model, signature matches `misr_step` reference, done at t+33.

Source files
------------

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and MISR step for the sweep capture engine
package sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } sweep_state_t;

    localparam int unsigned MISR_MAX_W = 32;

    // One MISR shift over the low `width` bits; anything above the width is cleared.
    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] din,
        input logic [31:0] poly,
        input int unsigned width = 16
    );
        logic [31:0] mask;
        logic [31:0] fb;
        mask = (width >= MISR_MAX_W) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = (((sig >> (width - 1)) & 32'd1) != 32'd0) ? poly : 32'd0;
        return ((sig << 1) ^ fb ^ din) & mask;
    endfunction

endpackage

// File: rtl/sweep_resp_ram.sv
// rtl/sweep_resp_ram.sv - simple dual-port response buffer with registered read
module sweep_resp_ram #(
    parameter int AW = 2,
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read samples the array before this edge's write lands, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sweep_capture_engine.sv
// rtl/sweep_capture_engine.sv - exhaustive stimulus sweep with capture, MISR and golden compare
module sweep_capture_engine
    import sweep_pkg::*;
#(
    parameter int               N_IN   = 2,
    parameter int               N_OUT  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = {SIG_W{1'b1}}
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] exp_out,
    input  logic [N_IN-1:0]  rd_addr,
    output logic [N_OUT-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             mismatch,
    output logic [N_IN:0]    fail_count,
    output logic [N_IN-1:0]  first_fail_addr
);

    localparam logic [N_IN-1:0] VEC_MAX     = '1;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE) - 8'd1;
    localparam sweep_state_t    FIRST_STATE = (SETTLE == 0) ? S_CAPTURE : S_HOLD;

    sweep_state_t     state_q;
    logic [N_IN-1:0]  vec_q;
    logic [7:0]       hold_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [31:0]      misr_full;
    logic             mismatch_q;
    logic [N_IN:0]    fail_count_q;
    logic [N_IN-1:0]  first_fail_q;
    logic             busy_q;
    logic             done_q;
    logic             capture;
    logic             miss;

    assign capture   = (state_q == S_CAPTURE);
    assign miss      = capture && (dut_out != exp_out);
    assign misr_full = misr_step(32'(sig_q), 32'(dut_out), 32'(POLY), SIG_W);
    assign sig_d     = misr_full[SIG_W-1:0];

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            hold_q       <= '0;
            sig_q        <= '0;
            mismatch_q   <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= FIRST_STATE;
                        vec_q        <= '0;
                        hold_q       <= '0;
                        sig_q        <= SEED;
                        mismatch_q   <= 1'b0;
                        fail_count_q <= '0;
                        first_fail_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (hold_q == SETTLE_LAST) begin
                        hold_q  <= '0;
                        state_q <= S_CAPTURE;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                S_CAPTURE: begin
                    sig_q <= sig_d;
                    if (miss) begin
                        fail_count_q <= fail_count_q + (N_IN+1)'(1);
                        mismatch_q   <= 1'b1;
                        if (!mismatch_q) begin
                            first_fail_q <= vec_q;
                        end
                    end
                    if (vec_q == VEC_MAX) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_q + N_IN'(1);
                        state_q <= FIRST_STATE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    sweep_resp_ram #(
        .AW(N_IN),
        .DW(N_OUT)
    ) u_ram (
        .clk  (CK),
        .reset(reset),
        .we   (capture),
        .waddr(vec_q),
        .wdata(dut_out),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    assign dut_in          = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign signature       = sig_q;
    assign mismatch        = mismatch_q;
    assign fail_count      = fail_count_q;
    assign first_fail_addr = first_fail_q;

endmodule

// File: tb/tb_sweep_capture_engine.sv
// tb/tb_sweep_capture_engine.sv - directed bench for the sweep capture engine
module tb_sweep_capture_engine;
    import sweep_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: N_IN=2, SETTLE=1, AND gate, golden selectable AND/OR
    logic        rst0, start0, or_mode;
    logic [1:0]  din0, rda0, ffa0;
    logic        dout0, exp0, rdd0, busy0, done0, mis0;
    logic [15:0] sig0;
    logic [2:0]  fc0;
    assign dout0 = &din0;
    assign exp0  = or_mode ? |din0 : &din0;

    sweep_capture_engine #(.N_IN(2), .N_OUT(1), .SETTLE(1)) u0 (
        .CK(clk), .reset(rst0), .start(start0), .dut_in(din0), .dut_out(dout0),
        .exp_out(exp0), .rd_addr(rda0), .rd_data(rdd0), .busy(busy0), .done(done0),
        .signature(sig0), .mismatch(mis0), .fail_count(fc0), .first_fail_addr(ffa0)
    );

    // instance 1: SETTLE=0
    logic        rst1, start1;
    logic [1:0]  din1, rda1, ffa1;
    logic        dout1, rdd1, busy1, done1, mis1;
    logic [15:0] sig1;
    logic [2:0]  fc1;
    assign dout1 = &din1;

    sweep_capture_engine #(.N_IN(2), .N_OUT(1), .SETTLE(0)) u1 (
        .CK(clk), .reset(rst1), .start(start1), .dut_in(din1), .dut_out(dout1),
        .exp_out(dout1), .rd_addr(rda1), .rd_data(rdd1), .busy(busy1), .done(done1),
        .signature(sig1), .mismatch(mis1), .fail_count(fc1), .first_fail_addr(ffa1)
    );

    // instance 2: N_IN=4, N_OUT=2, 2-bit sum of the input halves
    logic        rst2, start2;
    logic [3:0]  din2, rda2, ffa2;
    logic [1:0]  dout2, rdd2;
    logic        busy2, done2, mis2;
    logic [15:0] sig2;
    logic [4:0]  fc2;
    assign dout2 = din2[1:0] + din2[3:2];

    sweep_capture_engine #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u2 (
        .CK(clk), .reset(rst2), .start(start2), .dut_in(din2), .dut_out(dout2),
        .exp_out(dout2), .rd_addr(rda2), .rd_data(rdd2), .busy(busy2), .done(done2),
        .signature(sig2), .mismatch(mis2), .fail_count(fc2), .first_fail_addr(ffa2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int k, input logic v);
        case (k)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    function automatic logic [31:0] get_done(input int k);
        case (k)
            0: return 32'(done0);
            1: return 32'(done1);
            default: return 32'(done2);
        endcase
    endfunction

    function automatic logic [31:0] get_busy(input int k);
        case (k)
            0: return 32'(busy0);
            1: return 32'(busy1);
            default: return 32'(busy2);
        endcase
    endfunction

    function automatic logic [31:0] get_sig(input int k);
        case (k)
            0: return 32'(sig0);
            1: return 32'(sig1);
            default: return 32'(sig2);
        endcase
    endfunction

    function automatic logic [31:0] get_mis(input int k);
        case (k)
            0: return 32'(mis0);
            1: return 32'(mis1);
            default: return 32'(mis2);
        endcase
    endfunction

    // Pulses start, optionally re-pulses it mid-sweep, and returns edges from start sample to done.
    task automatic run(input int k, input bit mid_start, output int n);
        @(negedge clk);
        set_start(k, 1'b1);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            set_start(k, mid_start && (n == 3));
            if (n == 1) begin
                check($sformatf("u%0d first cycle done", k), get_done(k), 32'd0);
                check($sformatf("u%0d first cycle busy", k), get_busy(k), 32'd1);
                check($sformatf("u%0d seed loaded", k), get_sig(k), 32'hFFFF);
                check($sformatf("u%0d mismatch cleared", k), get_mis(k), 32'd0);
            end
            if (get_done(k) == 32'd1) break;
        end
        set_start(k, 1'b0);
    endtask

    task automatic read0(input logic [1:0] a, input logic e);
        @(negedge clk);
        rda0 = a;
        @(posedge clk);
        #1;
        check($sformatf("u0 rd_data[%0d]", a), 32'(rdd0), 32'(e));
    endtask

    initial begin
        int n;
        logic [31:0] model_sig;
        logic [1:0]  model_out;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        or_mode = 1'b0;
        rda0 = '0; rda1 = '0; rda2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset dut_in", 32'(din0), 32'd0);
        check("reset rd_data", 32'(rdd0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset done", 32'(done0), 32'd0);
        check("reset signature", 32'(sig0), 32'd0);
        check("reset mismatch", 32'(mis0), 32'd0);
        check("reset fail_count", 32'(fc0), 32'd0);
        check("reset first_fail_addr", 32'(ffa0), 32'd0);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // AND golden: clean sweep
        run(0, 1'b0, n);
        check("and done latency", 32'(n), 32'd9);
        check("and signature", 32'(sig0), 32'h0E1E);
        check("and mismatch", 32'(mis0), 32'd0);
        check("and fail_count", 32'(fc0), 32'd0);
        check("and busy after done", 32'(busy0), 32'd0);
        read0(2'd0, 1'b0);
        read0(2'd1, 1'b0);
        read0(2'd2, 1'b0);
        read0(2'd3, 1'b1);

        // OR golden, restarted from DONE, with a start pulse while busy
        or_mode = 1'b1;
        run(0, 1'b1, n);
        check("or done latency", 32'(n), 32'd9);
        check("or mismatch", 32'(mis0), 32'd1);
        check("or fail_count", 32'(fc0), 32'd2);
        check("or first_fail_addr", 32'(ffa0), 32'd1);
        check("or signature", 32'(sig0), 32'h0E1E);

        // Restart from DONE clears results and repeats the signature
        or_mode = 1'b0;
        run(0, 1'b0, n);
        check("rerun done latency", 32'(n), 32'd9);
        check("rerun signature", 32'(sig0), 32'h0E1E);
        check("rerun fail_count", 32'(fc0), 32'd0);
        check("rerun first_fail_addr", 32'(ffa0), 32'd0);

        // Reset in the cycle after the second capture
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        check("abort busy", 32'(busy0), 32'd0);
        check("abort done", 32'(done0), 32'd0);
        check("abort dut_in", 32'(din0), 32'd0);
        check("abort signature", 32'(sig0), 32'd0);
        check("abort rd_data", 32'(rdd0), 32'd0);
        run(0, 1'b0, n);
        check("post-abort latency", 32'(n), 32'd9);
        check("post-abort signature", 32'(sig0), 32'h0E1E);
        read0(2'd3, 1'b1);
        read0(2'd2, 1'b0);

        // SETTLE=0
        run(1, 1'b0, n);
        check("settle0 done latency", 32'(n), 32'd5);
        check("settle0 signature", 32'(sig1), 32'h0E1E);
        check("settle0 mismatch", 32'(mis1), 32'd0);

        // N_IN=4, N_OUT=2 adder sweep
        run(2, 1'b0, n);
        model_sig = 32'hFFFF;
        for (int i = 0; i < 16; i++) begin
            model_out = 2'(i) + 2'(i >> 2);
            model_sig = misr_step(model_sig, 32'(model_out), 32'h1021, 16);
        end
        check("wide done latency", 32'(n), 32'd33);
        check("wide signature", 32'(sig2), model_sig);
        check("wide fail_count", 32'(fc2), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rda2 = 4'(i);
            @(posedge clk);
            #1;
            model_out = 2'(i) + 2'(i >> 2);
            check($sformatf("wide rd_data[%0d]", i), 32'(rdd2), 32'(model_out));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
